// File: rtl/uart_pkg.sv
// Shared constants for the UART receive peripheral: bus addresses, RXCON bit map, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam logic [31:0] RXD_ADDR   = 32'h4000_001C;
    localparam logic [31:0] RXCON_ADDR = 32'h4000_0020;

    localparam int OVERSAMPLE = 16;

    localparam int RXCON_NE   = 0;
    localparam int RXCON_FERR = 1;
    localparam int RXCON_OVF  = 2;
    localparam int RXCON_IEN  = 3;
    localparam int RXCON_CNT  = 4;
    localparam int RXCON_PERR = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte-wide synchronous FIFO holding received characters; DEPTH must be a power of two.
// Latency: push visible at the head on the next cycle; head is combinational from the read pointer.
// Backpressure: push into a full FIFO is dropped unless a pop lands in the same cycle; pop when empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_dat,
    input  logic          pop,
    output logic [7:0]    head_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped 8N1 UART receiver, 16x oversampled, FIFO-buffered; UART_RX_PARITY_EN adds an even-parity bit.
// Latency: byte pushed at the stop-bit mid-sample (+2 cycle synchronizer); rdata combinational, irqout registered.
// Backpressure: none on the serial line; a byte arriving into a full FIFO is dropped and flagged as ovf.
module uart_rx_periph
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx_in,
    output logic        irqout
);

    localparam int          DIV_RAW  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int          DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam logic [31:0] DIV_LAST = 32'(DIV - 1);
    localparam int          CW       = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    logic            rx_s1;
    logic            rx_s2;
    logic            line;
    logic [31:0]     div_cnt;
    logic            tick;

    rx_state_t       state;
    rx_state_t       state_n;
    logic [3:0]      sc;
    logic [3:0]      sc_n;
    logic [2:0]      bi;
    logic [2:0]      bi_n;
    logic [7:0]      shreg;
    logic [7:0]      shreg_n;

    logic            fifo_push;
    logic            ferr_set;
    logic            ovf_set;
    logic            rx_pop;
    logic            con_wr;
    logic [7:0]      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [4:0]      cnt_wide;
    logic [2:0]      cnt_disp;

    logic            ferr;
    logic            ovf;
    logic            perr;
    logic            irq_en;
    logic            irq_q;
    logic            unused_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
        end
    end

    assign line = rx_s2;

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 32'd1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sc    <= '0;
            bi    <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            sc    <= sc_n;
            bi    <= bi_n;
            shreg <= shreg_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_set;
`endif

    always_comb begin
        state_n   = state;
        sc_n      = sc;
        bi_n      = bi;
        shreg_n   = shreg;
        fifo_push = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set  = 1'b0;
`endif
        if (tick) begin
            sc_n = sc + 4'd1;
            case (state)
                IDLE: begin
                    if (!line) begin
                        state_n = START;
                        sc_n    = '0;
                    end
                end
                // Re-check the line half a bit in to reject short glitches.
                START: begin
                    if (sc == 4'd7) begin
                        sc_n    = '0;
                        bi_n    = '0;
                        state_n = line ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sc == 4'd15) begin
                        shreg_n = {line, shreg[7:1]};
                        if (bi == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bi_n = bi + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sc == 4'd15) begin
                        perr_set = ^{shreg, line};
                        state_n  = STOP;
                    end
                end
`endif
                STOP: begin
                    if (sc == 4'd15) begin
                        fifo_push = line;
                        ferr_set  = ~line;
                        state_n   = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign rx_pop  = rd & (addr == RXD_ADDR);
    assign con_wr  = wr & (addr == RXCON_ADDR);
    assign ovf_set = fifo_push & fifo_full & ~rx_pop;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (shreg),
        .pop      (rx_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Error sets take priority over a software clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ferr   <= 1'b0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ferr_set) begin
                ferr <= 1'b1;
            end else if (con_wr && wdata[RXCON_FERR]) begin
                ferr <= 1'b0;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (con_wr && wdata[RXCON_OVF]) begin
                ovf <= 1'b0;
            end
            if (con_wr) begin
                irq_en <= wdata[RXCON_IEN];
            end
            irq_q <= irq_en & ~fifo_empty;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perr <= 1'b0;
        end else if (perr_set) begin
            perr <= 1'b1;
        end else if (con_wr && wdata[RXCON_PERR]) begin
            perr <= 1'b0;
        end
    end
    assign unused_wdata = ^{wdata[31:8], wdata[6:4], wdata[0]};
`else
    assign perr         = 1'b0;
    assign unused_wdata = ^{wdata[31:7], wdata[6:4], wdata[0]};
`endif

    assign irqout   = irq_q;
    assign cnt_wide = 5'(fifo_count);
    assign cnt_disp = (cnt_wide > 5'd7) ? 3'd7 : cnt_wide[2:0];

    always_comb begin
        rdata = '0;
        if (rd && addr == RXD_ADDR) begin
            rdata[7:0] = fifo_empty ? 8'h00 : fifo_head;
        end else if (rd && addr == RXCON_ADDR) begin
            rdata[7:0] = {perr, cnt_disp, irq_en, ovf, ferr, ~fifo_empty};
        end
    end

endmodule
